// File: rtl/data_buffer_mc.sv
// data_buffer_mc: capture buffer for commanded/feedback motor current of one channel
//   clk, rstn            : clock, asynchronous active-low reset
//   ctrl_wen/ctrl_wdata  : control write ([30] collect, [29] ring, [23:16] decim, [7:4] channel)
//   cmd_wen/cmd_chan/cmd_data : commanded-current write for any channel
//   fb_wen/fb_data       : feedback sample for the selected channel
//   chan, collecting     : selected channel, capture active
//   reg_raddr/reg_rdata  : RAM read port (1 clk latency), live wr_addr in [29:20]
//   status_rdata         : combinational capture status
module data_buffer_mc #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_CHAN    = 4,
   parameter int DECIM_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  ctrl_wen,
   input  logic [31:0]           ctrl_wdata,
   input  logic                  cmd_wen,
   input  logic [3:0]            cmd_chan,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic                  fb_wen,
   input  logic [DATA_WIDTH-1:0] fb_data,
   output logic [3:0]            chan,
   output logic                  collecting,
   input  logic [ADDR_WIDTH-1:0] reg_raddr,
   output logic [31:0]           reg_rdata,
   output logic [31:0]           status_rdata
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] chan_q, chan_d;
   logic ring_q, ring_d, wrapped_q, wrapped_d, ovf_q, ovf_d;
   logic [DECIM_WIDTH-1:0] decim_q, decim_d, cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [1:0] qcnt_q, qcnt_d, qn;
   logic [DATA_WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
   logic [21:0] mem [2**ADDR_WIDTH];
   logic [21:0] rdata_q, wdata;
   logic [9:0] wr10;
   logic start, fb_fire, cmd_ev, act, we, pop, push, last;
   assign start   = ctrl_wen && ctrl_wdata[30] && ctrl_wdata[7:4] != 4'd0 && ctrl_wdata[7:4] <= 4'(NUM_CHAN);
   assign fb_fire = fb_wen && cnt_q == decim_q;
   assign cmd_ev  = cmd_wen && cmd_chan == chan_q;
   // any control write pre-empts data writes in the same cycle
   assign act     = state_q == RUN && !ctrl_wen;
   assign we      = act && (fb_fire || qcnt_q != 2'd0 || cmd_ev);
   assign pop     = act && !fb_fire && qcnt_q != 2'd0;
   // the final one-shot write swallows any competing command silently
   assign last    = !ring_q && &wr_addr_q;
   assign push    = act && cmd_ev && (fb_fire || qcnt_q != 2'd0) && !last;
   assign qn      = qcnt_q - {1'b0, pop};
   assign wdata   = fb_fire ? {2'd3, chan_q, 16'(fb_data)} :
                    qcnt_q != 2'd0 ? {2'd2, chan_q, 16'(q0_q)} : {2'd1, chan_q, 16'(cmd_data)};
   assign wr10         = 10'(wr_addr_q);
   assign chan         = chan_q;
   assign collecting   = state_q == RUN;
   assign reg_rdata    = {rdata_q[21:20], wr10, rdata_q[19:0]};
   assign status_rdata = {collecting, state_q == DONE, wrapped_q, ovf_q, ring_q, 3'b0,
                          8'(decim_q), 6'b0, wr10};
   always_comb begin
      state_d   = state_q;
      chan_d    = chan_q;
      ring_d    = ring_q;
      decim_d   = decim_q;
      cnt_d     = cnt_q;
      wr_addr_d = wr_addr_q;
      wrapped_d = wrapped_q;
      ovf_d     = ovf_q;
      qcnt_d    = qcnt_q;
      q0_d      = q0_q;
      q1_d      = q1_q;
      if (start) begin
         state_d   = RUN;
         chan_d    = ctrl_wdata[7:4];
         ring_d    = ctrl_wdata[29];
         decim_d   = ctrl_wdata[16 +: DECIM_WIDTH];
         cnt_d     = '0;
         wr_addr_d = '0;
         wrapped_d = 1'b0;
         ovf_d     = 1'b0;
         qcnt_d    = 2'd0;
      end else if (ctrl_wen && !ctrl_wdata[30] && state_q == RUN) begin
         state_d = IDLE;
         qcnt_d  = 2'd0;
      end else if (act) begin
         if (fb_wen) cnt_d = fb_fire ? '0 : cnt_q + 1'b1;
         qcnt_d = qn;
         if (pop) q0_d = q1_q;
         if (push) begin
            if (qn == 2'd0) begin
               q0_d   = cmd_data;
               qcnt_d = 2'd1;
            end else if (qn == 2'd1) begin
               q1_d   = cmd_data;
               qcnt_d = 2'd2;
            end else ovf_d = 1'b1;
         end
         if (we) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (&wr_addr_q) begin
               wrapped_d = wrapped_q | ring_q;
               if (!ring_q) state_d = DONE;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         chan_q    <= 4'd1;
         ring_q    <= 1'b0;
         decim_q   <= '0;
         cnt_q     <= '0;
         wr_addr_q <= '0;
         wrapped_q <= 1'b0;
         ovf_q     <= 1'b0;
         qcnt_q    <= 2'd0;
         q0_q      <= '0;
         q1_q      <= '0;
      end else begin
         state_q   <= state_d;
         chan_q    <= chan_d;
         ring_q    <= ring_d;
         decim_q   <= decim_d;
         cnt_q     <= cnt_d;
         wr_addr_q <= wr_addr_d;
         wrapped_q <= wrapped_d;
         ovf_q     <= ovf_d;
         qcnt_q    <= qcnt_d;
         q0_q      <= q0_d;
         q1_q      <= q1_d;
      end
   end
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr_q] <= wdata;
      rdata_q <= mem[reg_raddr];
   end
endmodule

// File: tb/tb_data_buffer_mc.sv
// tb_data_buffer_mc: randomized and directed check of data_buffer_mc against a queue-based model
module tb_data_buffer_mc;
   logic clk, rstn, ctrl_wen, cmd_wen, fb_wen, collecting;
   logic [31:0] ctrl_wdata, reg_rdata, status_rdata;
   logic [3:0] cmd_chan, chan, reg_raddr;
   logic [15:0] cmd_data, fb_data;
   int n_chk = 0, n_fail = 0;
   bit m_run, m_done, m_wrap, m_ovf, m_ring;
   int m_wa, m_decim, m_cnt, m_chan;
   int q[$];
   logic [21:0] m_mem [16];
   bit m_vld [16];
   data_buffer_mc #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_CHAN(4), .DECIM_WIDTH(8)) dut (
      .clk(clk), .rstn(rstn), .ctrl_wen(ctrl_wen), .ctrl_wdata(ctrl_wdata),
      .cmd_wen(cmd_wen), .cmd_chan(cmd_chan), .cmd_data(cmd_data),
      .fb_wen(fb_wen), .fb_data(fb_data), .chan(chan), .collecting(collecting),
      .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .status_rdata(status_rdata));
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [31:0] ctl(input bit col, input bit ring, input int dec, input int ch);
      return {1'b0, col, ring, 5'b0, 8'(dec), 8'b0, 4'(ch), 4'b0};
   endfunction
   function automatic logic [31:0] m_status();
      return {m_run, m_done, m_wrap, m_ovf, m_ring, 3'b0, 8'(m_decim), 6'b0, 10'(m_wa)};
   endfunction
   task automatic m_reset();
      m_run = 0; m_done = 0; m_wrap = 0; m_ovf = 0; m_ring = 0;
      m_wa = 0; m_decim = 0; m_cnt = 0; m_chan = 1; q.delete();
   endtask
   task automatic model(input bit cw, input logic [31:0] cd, input bit mw, input logic [3:0] mc,
                        input logic [15:0] md, input bit fw, input logic [15:0] fd);
      int ch;
      bit fire, ev, wrote, direct, end_wr;
      logic [21:0] e;
      ch = int'(cd[7:4]);
      if (cw) begin
         if (cd[30] && ch >= 1 && ch <= 4) begin
            m_run = 1; m_done = 0; m_chan = ch; m_ring = cd[29]; m_decim = int'(cd[23:16]);
            m_wa = 0; m_wrap = 0; m_ovf = 0; m_cnt = 0; q.delete();
         end else if (!cd[30] && m_run) begin
            m_run = 0; q.delete();
         end
      end else if (m_run) begin
         fire = fw && m_cnt == m_decim;
         if (fw) m_cnt = fire ? 0 : m_cnt + 1;
         ev = mw && int'(mc) == m_chan;
         wrote = 1; direct = 0; e = '0;
         if (fire) e = {2'd3, 4'(m_chan), fd};
         else if (q.size() > 0) e = {2'd2, 4'(m_chan), 16'(q.pop_front())};
         else if (ev) begin e = {2'd1, 4'(m_chan), md}; direct = 1; end
         else wrote = 0;
         end_wr = wrote && !m_ring && m_wa == 15;
         if (ev && !direct && !end_wr) begin
            if (q.size() < 2) q.push_back(int'(md));
            else m_ovf = 1;
         end
         if (wrote) begin
            m_mem[m_wa] = e; m_vld[m_wa] = 1;
            if (m_wa == 15) begin
               if (m_ring) m_wrap = 1;
               else begin m_run = 0; m_done = 1; end
            end
            m_wa = (m_wa + 1) % 16;
         end
      end
   endtask
   task automatic step(input bit cw, input logic [31:0] cd, input bit mw, input logic [3:0] mc,
                       input logic [15:0] md, input bit fw, input logic [15:0] fd);
      @(negedge clk);
      ctrl_wen = cw; ctrl_wdata = cd; cmd_wen = mw; cmd_chan = mc; cmd_data = md;
      fb_wen = fw; fb_data = fd;
      @(posedge clk);
      model(cw, cd, mw, mc, md, fw, fd);
      #1;
      chk("status", status_rdata, m_status());
      chk("chan", 32'(chan), 32'(m_chan));
      chk("collecting", 32'(collecting), 32'(m_run));
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic fb(input logic [15:0] d);
      step(0, 0, 0, 0, 0, 1, d);
   endtask
   task automatic start(input bit ring, input int dec, input int ch);
      step(1, ctl(1, ring, dec, ch), 0, 0, 0, 0, 0);
   endtask
   task automatic rd(input int a);
      logic [21:0] e;
      e = m_mem[a];
      @(negedge clk);
      ctrl_wen = 0; cmd_wen = 0; fb_wen = 0; reg_raddr = 4'(a);
      @(posedge clk);
      model(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rdata", reg_rdata, {e[21:20], 10'(m_wa), e[19:0]});
   endtask
   initial begin
      rstn = 0; ctrl_wen = 0; ctrl_wdata = 0; cmd_wen = 0; cmd_chan = 0; cmd_data = 0;
      fb_wen = 0; fb_data = 0; reg_raddr = 0;
      m_reset();
      #12;
      chk("reset_status", status_rdata, 32'h0);
      chk("reset_chan", 32'(chan), 32'd1);
      @(negedge clk) rstn = 1;
      start(0, 0, 0);
      start(0, 0, 5);
      chk("bad_start_idle", status_rdata, 32'h0);
      start(0, 0, 2);
      fb(16'h0011); fb(16'h0022); fb(16'h0033);
      rd(0); chk("t1_e0", reg_rdata, 32'hC0320011);
      rd(1); chk("t1_e1", reg_rdata, 32'hC0320022);
      rd(2); chk("t1_e2", reg_rdata, 32'hC0320033);
      step(0, 0, 1, 4'd2, 16'h1234, 1, 16'h0044);
      idle(1);
      step(0, 0, 1, 4'd3, 16'h5555, 0, 0);
      idle(1);
      rd(4); chk("t2_deferred", reg_rdata, 32'h80521234);
      for (int i = 0; i < 4; i++) step(0, 0, i < 3, 4'd2, 16'(16'hA0 + i), 1, 16'(i));
      chk("t3_ovf", 32'(status_rdata[28]), 32'd1);
      idle(3);
      for (int a = 5; a < 11; a++) rd(a);
      start(1, 0, 2);
      for (int i = 0; i < 20; i++) fb(16'(i));
      chk("t4_ring", status_rdata, 32'hA8000004);
      start(0, 0, 2);
      for (int i = 0; i < 20; i++) fb(16'(16'h100 + i));
      chk("t4_oneshot", status_rdata, 32'h40000000);
      for (int a = 0; a < 16; a++) rd(a);
      start(0, 3, 1);
      for (int i = 1; i <= 12; i++) fb(16'(i));
      for (int a = 0; a < 3; a++) rd(a);
      start(1, 0, 3);
      fb(16'h7777);
      @(negedge clk);
      #2 rstn = 0;
      #1;
      m_reset();
      chk("async_rst_status", status_rdata, 32'h0);
      chk("async_rst_chan", 32'(chan), 32'd1);
      chk("async_rst_coll", 32'(collecting), 32'd0);
      @(negedge clk) rstn = 1;
      for (int s = 0; s < 8; s++) begin
         start(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 4));
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 39) == 0)
               step(1, ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 2), $urandom_range(0, 5)), 0, 0, 0, 0, 0);
            else
               step(0, 0, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 4)), 16'($urandom),
                    1'($urandom_range(0, 1)), 16'($urandom));
         end
         idle(3);
         for (int a = 0; a < 16; a++) if (m_vld[a]) rd(a);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
